// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: receive-side checker for looped-back VGA. Measures line and
// frame timing from the synchronised sync inputs, declares lock once timing is
// stable, and publishes the bounding box of lit pixels once per frame.
module vga_timing_monitor #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned TIMEOUT_CYC = 1048576
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync_h,
  input  logic             sync_v,
  input  logic [2:0]       vga,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_sync_w,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_sync_w,
  output logic             locked,
  output logic             frame_start,
  output logic             bbox_valid,
  output logic             bbox_empty,
  output logic [CNT_W-1:0] bbox_x_min,
  output logic [CNT_W-1:0] bbox_x_max,
  output logic [CNT_W-1:0] bbox_y_min,
  output logic [CNT_W-1:0] bbox_y_max
);

  localparam int unsigned      TO_W    = $clog2(TIMEOUT_CYC + 1) + 1;
  localparam int unsigned      MC_W    = $clog2(LOCK_FRAMES + 1) + 1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAXV    = '1;
  localparam logic [TO_W-1:0]  TO_LIM  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [MC_W-1:0]  MC_LOCK = MC_W'(LOCK_FRAMES);

  typedef enum logic [1:0] {S_SEARCH, S_MEASURE, S_LOCKED} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == MAXV) ? v : v + ONE;
  endfunction

  logic [2:0]       r_h_q, r_v_q;
  logic [2:0]       r_vga_q1, r_vga_q2;
  logic [CNT_W-1:0] r_x, r_y, r_hlow, r_vlow;
  logic [TO_W-1:0]  r_to;
  logic             r_vs_pend;
  logic             r_line_mis;
  logic             r_first;
  logic [MC_W-1:0]  r_match;
  state_t           r_state;
  logic             r_rlit;
  logic [CNT_W-1:0] r_rx_min, r_rx_max, r_ry_min, r_ry_max;

  logic             w_h_dly, w_v_dly, w_ls, w_vfall, w_fs, w_lit, w_to;
  logic [CNT_W-1:0] w_x_cur, w_y_cur;
  logic             w_line_bad, w_frame_bad;
  logic [MC_W-1:0]  w_match_nx;

  // Delayed signals are the 2nd flop; edges compare the 2nd against the 3rd.
  assign w_h_dly = r_h_q[1];
  assign w_v_dly = r_v_q[1];
  assign w_ls    = r_h_q[2] & ~r_h_q[1];
  assign w_vfall = r_v_q[2] & ~r_v_q[1];
  assign w_fs    = w_ls & (r_vs_pend | w_vfall);
  assign w_lit   = |r_vga_q2;
  assign w_to    = !w_ls && (r_to >= TO_LIM);

  // Position of the current clock; r_x/r_y hold the previous clock's value.
  assign w_x_cur = w_ls ? ONE : sat_inc(r_x);
  assign w_y_cur = w_fs ? ONE : (w_ls ? sat_inc(r_y) : r_y);

  // The line closing on this LS is compared with the previously published line.
  assign w_line_bad  = (r_x != h_total) || (r_hlow != h_sync_w) ||
                       (r_x == MAXV) || (r_hlow == MAXV);
  assign w_frame_bad = r_line_mis || w_line_bad || (r_y == MAXV) ||
                       (!r_first && (r_y != v_total));
  assign w_match_nx  = r_match + 1'b1;

  // Input synchronisers plus the third edge-detect stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_q    <= '0;
      r_v_q    <= '0;
      r_vga_q1 <= '0;
      r_vga_q2 <= '0;
    end else begin
      r_h_q    <= {r_h_q[1:0], sync_h};
      r_v_q    <= {r_v_q[1:0], sync_v};
      r_vga_q1 <= vga;
      r_vga_q2 <= r_vga_q1;
    end
  end

  // Pixel/line position, sync-low counters, vsync pending flag, timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x       <= '0;
      r_y       <= '0;
      r_hlow    <= '0;
      r_vlow    <= '0;
      r_vs_pend <= 1'b0;
      r_to      <= '0;
    end else begin
      r_x <= w_x_cur;
      r_y <= w_to ? '0 : w_y_cur;
      if (w_ls)
        r_hlow <= ONE;
      else if (!w_h_dly)
        r_hlow <= sat_inc(r_hlow);
      if (w_fs)
        r_vlow <= w_v_dly ? '0 : ONE;
      else if (w_ls && !w_v_dly)
        r_vlow <= sat_inc(r_vlow);
      if (w_fs)
        r_vs_pend <= 1'b0;
      else if (w_vfall)
        r_vs_pend <= 1'b1;
      if (w_ls)
        r_to <= '0;
      else if (r_to != '1)
        r_to <= r_to + 1'b1;
    end
  end

  // Timing measurements and lock FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_SEARCH;
      r_match     <= '0;
      r_first     <= 1'b0;
      r_line_mis  <= 1'b0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      h_total     <= '0;
      h_sync_w    <= '0;
      v_total     <= '0;
      v_sync_w    <= '0;
    end else begin
      frame_start <= w_fs;
      if (w_to) begin
        r_state    <= S_SEARCH;
        r_match    <= '0;
        r_line_mis <= 1'b0;
        locked     <= 1'b0;
        h_total    <= '0;
        h_sync_w   <= '0;
        v_total    <= '0;
        v_sync_w   <= '0;
      end else begin
        if (w_ls) begin
          h_total  <= r_x;
          h_sync_w <= r_hlow;
          if (w_line_bad)
            r_line_mis <= 1'b1;
        end
        // The LS that is also FS closes the old frame: its line check is folded
        // into w_frame_bad and the sticky flag restarts clear for the new frame.
        if (w_fs) begin
          v_total    <= r_y;
          v_sync_w   <= r_vlow;
          r_line_mis <= 1'b0;
          case (r_state)
            S_SEARCH: begin
              r_state <= S_MEASURE;
              r_match <= '0;
              r_first <= 1'b1;
              locked  <= 1'b0;
            end
            S_MEASURE: begin
              r_first <= 1'b0;
              if (w_frame_bad) begin
                r_match <= '0;
              end else begin
                r_match <= w_match_nx;
                if (w_match_nx >= MC_LOCK) begin
                  r_state <= S_LOCKED;
                  locked  <= 1'b1;
                end
              end
            end
            S_LOCKED: begin
              if (w_frame_bad) begin
                r_state <= S_MEASURE;
                r_match <= '0;
                locked  <= 1'b0;
              end
            end
            default: begin
              r_state <= S_SEARCH;
              locked  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  // Running lit-pixel box, published and restarted at each frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rlit     <= 1'b0;
      r_rx_min   <= '0;
      r_rx_max   <= '0;
      r_ry_min   <= '0;
      r_ry_max   <= '0;
      bbox_valid <= 1'b0;
      bbox_empty <= 1'b1;
      bbox_x_min <= '0;
      bbox_x_max <= '0;
      bbox_y_min <= '0;
      bbox_y_max <= '0;
    end else begin
      bbox_valid <= w_fs;
      if (w_to) begin
        r_rlit     <= 1'b0;
        bbox_empty <= 1'b1;
        bbox_x_min <= '0;
        bbox_x_max <= '0;
        bbox_y_min <= '0;
        bbox_y_max <= '0;
      end else if (w_fs) begin
        bbox_empty <= !r_rlit;
        bbox_x_min <= r_rlit ? r_rx_min : '0;
        bbox_x_max <= r_rlit ? r_rx_max : '0;
        bbox_y_min <= r_rlit ? r_ry_min : '0;
        bbox_y_max <= r_rlit ? r_ry_max : '0;
        r_rlit     <= w_lit;
        r_rx_min   <= w_lit ? w_x_cur : '0;
        r_rx_max   <= w_lit ? w_x_cur : '0;
        r_ry_min   <= w_lit ? w_y_cur : '0;
        r_ry_max   <= w_lit ? w_y_cur : '0;
      end else if (w_lit) begin
        r_rlit <= 1'b1;
        if (!r_rlit) begin
          r_rx_min <= w_x_cur;
          r_rx_max <= w_x_cur;
          r_ry_min <= w_y_cur;
          r_ry_max <= w_y_cur;
        end else begin
          if (w_x_cur < r_rx_min) r_rx_min <= w_x_cur;
          if (w_x_cur > r_rx_max) r_rx_max <= w_x_cur;
          if (w_y_cur < r_ry_min) r_ry_min <= w_y_cur;
          if (w_y_cur > r_ry_max) r_ry_max <= w_y_cur;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb_vga_timing_monitor: directed scenarios on a scaled-down raster
// (40 clocks/line, 6 sync clocks, 20 lines/frame, 2 sync lines).
module tb_vga_timing_monitor;

  localparam int CNT_W = 16;
  localparam int H_TOT = 40;
  localparam int H_SW  = 6;
  localparam int V_TOT = 20;
  localparam int V_SW  = 2;
  localparam int TO    = 300;
  localparam int LF    = 2;

  logic             clk, rst_n, sync_h, sync_v;
  logic [2:0]       vga;
  logic [CNT_W-1:0] h_total, h_sync_w, v_total, v_sync_w;
  logic             locked, frame_start, bbox_valid, bbox_empty;
  logic [CNT_W-1:0] bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max;

  vga_timing_monitor #(
    .CNT_W(CNT_W),
    .LOCK_FRAMES(LF),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sync_h(sync_h), .sync_v(sync_v), .vga(vga),
    .h_total(h_total), .h_sync_w(h_sync_w), .v_total(v_total), .v_sync_w(v_sync_w),
    .locked(locked), .frame_start(frame_start), .bbox_valid(bbox_valid),
    .bbox_empty(bbox_empty), .bbox_x_min(bbox_x_min), .bbox_x_max(bbox_x_max),
    .bbox_y_min(bbox_y_min), .bbox_y_max(bbox_y_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Lit rectangle in x_pos/y_pos units; bx0 > bx1 means black video.
  int bx0 = 1, bx1 = 0, by0 = 1, by1 = 0;

  // Outputs captured on every frame_start pulse, indexed by frame-start number.
  int               fs_cnt = 0;
  logic             s_locked [256];
  logic             s_empty  [256];
  logic             s_valid  [256];
  logic [CNT_W-1:0] s_htot [256], s_hsw [256], s_vtot [256], s_vsw [256];
  logic [CNT_W-1:0] s_xmin [256], s_xmax [256], s_ymin [256], s_ymax [256];

  always @(negedge clk) begin
    if (frame_start === 1'b1) begin
      fs_cnt = fs_cnt + 1;
      s_locked[fs_cnt % 256] = locked;
      s_empty[fs_cnt % 256]  = bbox_empty;
      s_valid[fs_cnt % 256]  = bbox_valid;
      s_htot[fs_cnt % 256]   = h_total;
      s_hsw[fs_cnt % 256]    = h_sync_w;
      s_vtot[fs_cnt % 256]   = v_total;
      s_vsw[fs_cnt % 256]    = v_sync_w;
      s_xmin[fs_cnt % 256]   = bbox_x_min;
      s_xmax[fs_cnt % 256]   = bbox_x_max;
      s_ymin[fs_cnt % 256]   = bbox_y_min;
      s_ymax[fs_cnt % 256]   = bbox_y_max;
    end
  end

  // One line (0-based index l in frame) of len clocks; pin pixel k has x_pos k+1.
  task automatic run_line(input int l, input int len);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      sync_h = (k < H_SW) ? 1'b0 : 1'b1;
      sync_v = (l < V_SW) ? 1'b0 : 1'b1;
      vga = ((k + 1) >= bx0 && (k + 1) <= bx1 && (l + 1) >= by0 && (l + 1) <= by1)
            ? 3'b010 : 3'b000;
    end
  endtask

  task automatic run_lines(input int start, input int n);
    for (int i = 0; i < n; i++) run_line((start + i) % V_TOT, H_TOT);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b want 0", locked); end
    checks++; if ({h_total, h_sync_w, v_total, v_sync_w} !== '0) begin errors++;
      $display("FAIL reset_meas: got %0d/%0d/%0d/%0d want 0", h_total, h_sync_w, v_total, v_sync_w); end
    checks++; if ({frame_start, bbox_valid} !== 2'b00) begin errors++;
      $display("FAIL reset_pulses: got %0b%0b want 00", frame_start, bbox_valid); end
    checks++; if (bbox_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b want 1", bbox_empty); end
    checks++; if ({bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max} !== '0) begin errors++;
      $display("FAIL reset_bbox: got %0d/%0d/%0d/%0d want 0", bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max); end
    rst_n = 1'b1;
  endtask

  task automatic test_lock;
    int base;
    base = fs_cnt;
    run_lines(V_SW, V_TOT - V_SW);
    run_lines(0, V_TOT);
    run_lines(0, V_TOT);
    run_lines(0, 1);
    checks++; if (fs_cnt - base !== 3) begin errors++; $display("FAIL lock_fs_count: got %0d want 3", fs_cnt - base); end
    checks++; if (s_locked[(base + 2) % 256] !== 1'b0) begin errors++; $display("FAIL lock_fs2: got %0b want 0", s_locked[(base + 2) % 256]); end
    checks++; if (s_locked[(base + 3) % 256] !== 1'b1) begin errors++; $display("FAIL lock_fs3: got %0b want 1", s_locked[(base + 3) % 256]); end
    checks++; if (s_htot[(base + 3) % 256] !== 16'd40) begin errors++; $display("FAIL lock_h_total: got %0d want 40", s_htot[(base + 3) % 256]); end
    checks++; if (s_hsw[(base + 3) % 256] !== 16'd6) begin errors++; $display("FAIL lock_h_sync_w: got %0d want 6", s_hsw[(base + 3) % 256]); end
    checks++; if (s_vtot[(base + 3) % 256] !== 16'd20) begin errors++; $display("FAIL lock_v_total: got %0d want 20", s_vtot[(base + 3) % 256]); end
    checks++; if (s_vsw[(base + 3) % 256] !== 16'd2) begin errors++; $display("FAIL lock_v_sync_w: got %0d want 2", s_vsw[(base + 3) % 256]); end
    checks++; if (s_empty[(base + 3) % 256] !== 1'b1) begin errors++; $display("FAIL lock_empty: got %0b want 1", s_empty[(base + 3) % 256]); end
    checks++; if (s_valid[(base + 3) % 256] !== 1'b1) begin errors++; $display("FAIL lock_bbox_valid: got %0b want 1", s_valid[(base + 3) % 256]); end
  endtask

  task automatic test_bbox;
    int i;
    bx0 = 7; bx1 = 18; by0 = 4; by1 = 9;
    run_lines(1, V_TOT - 1);
    bx0 = 1; bx1 = 0;
    run_lines(0, 1);
    i = fs_cnt % 256;
    checks++; if ({s_xmin[i], s_xmax[i]} !== {16'd7, 16'd18}) begin errors++;
      $display("FAIL bbox_block_x: got %0d/%0d want 7/18", s_xmin[i], s_xmax[i]); end
    checks++; if ({s_ymin[i], s_ymax[i]} !== {16'd4, 16'd9}) begin errors++;
      $display("FAIL bbox_block_y: got %0d/%0d want 4/9", s_ymin[i], s_ymax[i]); end
    checks++; if ({s_empty[i], s_locked[i]} !== 2'b01) begin errors++;
      $display("FAIL bbox_block_flags: got empty=%0b locked=%0b want 0/1", s_empty[i], s_locked[i]); end
    // A pixel on the frame-start clock belongs to the frame it starts.
    run_lines(1, V_TOT - 1);
    bx0 = 1; bx1 = 1; by0 = 1; by1 = 1;
    run_lines(0, 1);
    i = fs_cnt % 256;
    checks++; if ({s_empty[i], s_xmin[i], s_xmax[i]} !== {1'b1, 32'd0}) begin errors++;
      $display("FAIL bbox_fs_pixel_old: got empty=%0b x=%0d/%0d want 1 0/0", s_empty[i], s_xmin[i], s_xmax[i]); end
    bx0 = 1; bx1 = 0;
    run_lines(1, V_TOT - 1);
    run_lines(0, 1);
    i = fs_cnt % 256;
    checks++; if ({s_empty[i], s_xmin[i], s_xmax[i], s_ymin[i], s_ymax[i]} !== {1'b0, 16'd1, 16'd1, 16'd1, 16'd1}) begin errors++;
      $display("FAIL bbox_fs_pixel_new: got empty=%0b %0d/%0d/%0d/%0d want 0 1/1/1/1",
               s_empty[i], s_xmin[i], s_xmax[i], s_ymin[i], s_ymax[i]); end
  endtask

  task automatic test_all_lit;
    int i, p;
    bx0 = 1; bx1 = H_TOT; by0 = 1; by1 = V_TOT;
    run_lines(1, V_TOT - 1);
    run_lines(0, V_TOT);
    bx0 = 1; bx1 = 0;
    run_lines(0, 1);
    i = fs_cnt % 256;
    p = (fs_cnt - 1) % 256;
    checks++; if ({s_ymin[p], s_ymax[p]} !== {16'd2, 16'd20}) begin errors++;
      $display("FAIL all_lit_partial_y: got %0d/%0d want 2/20", s_ymin[p], s_ymax[p]); end
    checks++; if ({s_xmin[i], s_xmax[i]} !== {16'd1, 16'd40}) begin errors++;
      $display("FAIL all_lit_x: got %0d/%0d want 1/40", s_xmin[i], s_xmax[i]); end
    checks++; if ({s_ymin[i], s_ymax[i]} !== {16'd1, 16'd20}) begin errors++;
      $display("FAIL all_lit_y: got %0d/%0d want 1/20", s_ymin[i], s_ymax[i]); end
    checks++; if ({s_empty[i], s_locked[i]} !== 2'b01) begin errors++;
      $display("FAIL all_lit_flags: got empty=%0b locked=%0b want 0/1", s_empty[i], s_locked[i]); end
  endtask

  task automatic test_line_mismatch;
    int base;
    run_lines(1, V_TOT - 1);
    base = fs_cnt;
    for (int l = 0; l < V_TOT; l++) begin
      run_line(l, (l == 5) ? H_TOT + 1 : H_TOT);
      if (l == 6) begin
        checks++; if (h_total !== 16'd41) begin errors++; $display("FAIL mis_long_h_total: got %0d want 41", h_total); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL mis_locked_midframe: got %0b want 1", locked); end
      end
    end
    run_lines(0, 1);
    run_lines(1, V_TOT - 1);
    run_lines(0, 1);
    run_lines(1, V_TOT - 1);
    run_lines(0, 1);
    checks++; if (fs_cnt - base !== 4) begin errors++; $display("FAIL mis_fs_count: got %0d want 4", fs_cnt - base); end
    checks++; if (s_locked[(base + 2) % 256] !== 1'b0) begin errors++; $display("FAIL mis_unlock: got %0b want 0", s_locked[(base + 2) % 256]); end
    checks++; if (s_locked[(base + 3) % 256] !== 1'b0) begin errors++; $display("FAIL mis_one_good: got %0b want 0", s_locked[(base + 3) % 256]); end
    checks++; if (s_locked[(base + 4) % 256] !== 1'b1) begin errors++; $display("FAIL mis_relock: got %0b want 1", s_locked[(base + 4) % 256]); end
  endtask

  task automatic test_timeout;
    int base;
    sync_h = 1'b1; sync_v = 1'b1; vga = 3'b000;
    // Last hsync fall was 40 clocks ago at the start of the line just run.
    repeat (TO - 50) @(negedge clk);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL to_early: got %0b want 1", locked); end
    repeat (20) @(negedge clk);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL to_locked: got %0b want 0", locked); end
    checks++; if ({h_total, h_sync_w, v_total, v_sync_w} !== '0) begin errors++;
      $display("FAIL to_meas: got %0d/%0d/%0d/%0d want 0", h_total, h_sync_w, v_total, v_sync_w); end
    checks++; if (bbox_empty !== 1'b1) begin errors++; $display("FAIL to_empty: got %0b want 1", bbox_empty); end
    base = fs_cnt;
    run_lines(2, V_TOT - 2);
    run_lines(0, V_TOT);
    run_lines(0, V_TOT);
    run_lines(0, 1);
    checks++; if (fs_cnt - base !== 3) begin errors++; $display("FAIL to_resume_fs: got %0d want 3", fs_cnt - base); end
    checks++; if (s_locked[(base + 2) % 256] !== 1'b0) begin errors++; $display("FAIL to_resume_fs2: got %0b want 0", s_locked[(base + 2) % 256]); end
    checks++; if (s_locked[(base + 3) % 256] !== 1'b1) begin errors++; $display("FAIL to_resume_fs3: got %0b want 1", s_locked[(base + 3) % 256]); end
    checks++; if (s_vtot[(base + 3) % 256] !== 16'd20) begin errors++; $display("FAIL to_resume_v_total: got %0d want 20", s_vtot[(base + 3) % 256]); end
  endtask

  task automatic test_reset_midframe;
    int base;
    base = fs_cnt;
    fork
      run_lines(1, V_TOT - 1);
      begin
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if ({locked, bbox_empty} !== 2'b01) begin errors++;
          $display("FAIL midrst_flags: got locked=%0b empty=%0b want 0/1", locked, bbox_empty); end
        checks++; if ({h_total, v_total, bbox_x_max, bbox_y_max} !== '0) begin errors++;
          $display("FAIL midrst_meas: got %0d/%0d/%0d/%0d want 0", h_total, v_total, bbox_x_max, bbox_y_max); end
        rst_n = 1'b1;
      end
    join
    run_lines(0, V_TOT);
    run_lines(0, V_TOT);
    run_lines(0, 1);
    checks++; if (fs_cnt - base !== 3) begin errors++; $display("FAIL midrst_fs_count: got %0d want 3", fs_cnt - base); end
    checks++; if (s_locked[(base + 2) % 256] !== 1'b0) begin errors++; $display("FAIL midrst_fs2: got %0b want 0", s_locked[(base + 2) % 256]); end
    checks++; if (s_locked[(base + 3) % 256] !== 1'b1) begin errors++; $display("FAIL midrst_fs3: got %0b want 1", s_locked[(base + 3) % 256]); end
  endtask

  initial begin
    rst_n = 1'b0; sync_h = 1'b1; sync_v = 1'b1; vga = 3'b000;
    test_reset();
    test_lock();
    test_bbox();
    test_all_lit();
    test_line_mismatch();
    test_timeout();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
